// File: rtl/store_commit_queue.sv
// Post-retirement store queue: buffers retired stores and issues them in order to the DCache,
// one outstanding request at a time, with a zero-latency load address conflict probe.
module store_commit_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        Clk,
    input  logic        Rest,
    input  logic        RetireStoreAble,
    input  logic [31:0] RetirePAddr,
    input  logic [31:0] RetireData,
    input  logic [1:0]  RetireType,
    output logic        StoreAble,
    output logic [31:0] StoreAddr,
    output logic [31:0] StoreDate,
    output logic [3:0]  StoreMask,
    input  logic        StoreBuzy,
    input  logic        StoreAck,
    input  logic        StoreTrapIn,
    input  logic [31:0] LoadProbeAddr,
    output logic        LoadConflict,
    output logic        StoreFull,
    output logic        QueueEmpty,
    output logic        Overflow,
    output logic        StoreErr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            err_q, err_d;

    logic [31:0]     addr_q [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [1:0]      type_q [DEPTH];

    logic            pop, push;
    logic            req;
    logic [31:0]     head_addr, head_data;
    logic [1:0]      head_type;

    assign pop  = (state_q == StWait) && StoreAck;
    // A full queue still accepts a store when the head pops in the same cycle.
    assign push = RetireStoreAble && ((count_q != FullCnt) || pop);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q | (RetireStoreAble & ~push);
        err_d      = pop & StoreTrapIn;
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if ((count_q != '0) || push) state_d = StReq;
            StReq:  if (!StoreBuzy) state_d = StWait;
            StWait: if (StoreAck) state_d = (count_d != '0) ? StReq : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            state_q    <= StIdle;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    // Entry storage needs no reset; validity is derived from head and count.
    always_ff @(posedge Clk) begin
        if (!Rest && push) begin
            addr_q[tail_q] <= RetirePAddr;
            data_q[tail_q] <= RetireData;
            type_q[tail_q] <= RetireType;
        end
    end

    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign head_type = type_q[head_q];
    assign req       = (state_q == StReq);

    always_comb begin
        StoreAddr = '0;
        StoreDate = '0;
        StoreMask = '0;
        if (req) begin
            StoreAddr = {head_addr[31:2], 2'b00};
            case (head_type)
                2'd0: begin
                    StoreDate = {4{head_data[7:0]}};
                    StoreMask = 4'b0001 << head_addr[1:0];
                end
                2'd1: begin
                    StoreDate = {2{head_data[15:0]}};
                    StoreMask = 4'b0011 << {head_addr[1], 1'b0};
                end
                2'd2: begin
                    StoreDate = head_data;
                    StoreMask = 4'b1111;
                end
                default: begin
                    StoreDate = head_data;
                    StoreMask = 4'b0000;
                end
            endcase
        end
    end

    // Entry i is valid when its distance from head is below count.
    always_comb begin
        LoadConflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (({1'b0, AW'(i) - head_q} < count_q) &&
                (addr_q[i][31:2] == LoadProbeAddr[31:2])) begin
                LoadConflict = 1'b1;
            end
        end
    end

    assign StoreAble  = req;
    assign StoreFull  = (count_q == FullCnt);
    assign QueueEmpty = (count_q == '0);
    assign Overflow   = overflow_q;
    assign StoreErr   = err_q;

endmodule
